// File: rtl/bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// bcd_seg_scan
//
// Scans a 4-digit multiplexed 7-segment display from a 16-bit packed BCD
// value. Each digit gets one slot of SCAN_DIV clocks; four slots make a
// frame. New values are double-buffered and only reach the display register
// on a frame boundary, so one frame never mixes old and new digits.
// Also provides leading-zero blanking, per-digit decimal points, a
// whole-display blink and an error flag for non-decimal nibbles.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   bcd       packed BCD value: [15:12] thousands ... [3:0] ones
//   valid     single-cycle strobe that captures bcd
//   blank_lz  1 = blank leading zeros (digit 0 is never blanked)
//   blink_en  1 = blink the whole display
//   dp_mask   bit i lights the decimal point on digit i (sampled live)
//   an        digit enables, active-low, an[0] = ones
//   seg       segments gfedcba, active-low
//   dp        decimal point, active-low
//   frame     one-cycle pulse on the frame-boundary cycle
//   err       high while the displayed value holds a nibble > 9
// ---------------------------------------------------------------------------
module bcd_seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd,
    input  logic        valid,
    input  logic        blank_lz,
    input  logic        blink_en,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame,
    output logic        err
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt_reg;
    logic [1:0]    digit_idx_reg;
    logic [15:0]   pend_reg;
    logic          pend_flag_reg;
    logic [15:0]   disp_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;

    logic [3:0]    an_reg,  an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg,  dp_next;
    logic          err_reg, err_next;

    logic          tick;
    logic          boundary;

    assign tick     = (scan_cnt_reg == SCAN_MAX);
    // The 3->0 index transition happens on this cycle.
    assign boundary = tick && (digit_idx_reg == 2'd3);

    // -----------------------------------------------------------------------
    // Segment decode (gfedcba, active-low); anything above 9 shows a dash.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b0111111;
        endcase
        return code;
    endfunction

    // -----------------------------------------------------------------------
    // Per-digit decode, blanking and range check.
    // -----------------------------------------------------------------------
    logic [3:0] blank_digit;
    logic [3:0] bad_nib;
    logic [6:0] digit_seg [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = disp_reg[4*gi +: 4];
            assign bad_nib[gi] = (nib > 4'd9);
            if (gi == 0) begin : g_ones
                // The ones digit always shows, so zero reads as "0".
                assign blank_digit[gi] = 1'b0;
            end else begin : g_upper
                // Blank when this nibble and every higher one are zero.
                assign blank_digit[gi] = blank_lz && (disp_reg[15:4*gi] == '0);
            end
            assign digit_seg[gi] = blank_digit[gi] ? 7'b1111111 : seg_code(nib);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Scan prescaler and digit index.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
        end else begin
            if (tick) begin
                scan_cnt_reg  <= '0;
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end else begin
                scan_cnt_reg  <= scan_cnt_reg + SW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Double-buffered capture. A valid on the boundary cycle bypasses the
    // pending register so the new frame starts with it immediately.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg      <= '0;
            pend_flag_reg <= 1'b0;
            disp_reg      <= '0;
        end else begin
            if (valid && boundary) begin
                disp_reg      <= bcd;
                pend_flag_reg <= 1'b0;
            end else begin
                if (boundary && pend_flag_reg) begin
                    disp_reg      <= pend_reg;
                    pend_flag_reg <= 1'b0;
                end
                if (valid) begin
                    pend_reg      <= bcd;
                    pend_flag_reg <= 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Free-running blink timer; phase flips on every wrap.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            if (blink_cnt_reg == BLINK_MAX) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg   <= blink_cnt_reg + BW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stage: registered from the current index and display register.
    // Blink only darkens anodes and dp; seg keeps its normal value.
    // -----------------------------------------------------------------------
    always_comb begin
        an_next  = 4'b1111;
        an_next[digit_idx_reg] = 1'b0;
        seg_next = digit_seg[digit_idx_reg];
        dp_next  = blank_digit[digit_idx_reg] ? 1'b1 : ~dp_mask[digit_idx_reg];
        err_next = |bad_nib;
        if (blink_en && blink_phase_reg) begin
            an_next = 4'b1111;
            dp_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_reg  <= 4'b1111;
            seg_reg <= 7'b1111111;
            dp_reg  <= 1'b1;
            err_reg <= 1'b0;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            err_reg <= err_next;
        end
    end

    assign an    = an_reg;
    assign seg   = seg_reg;
    assign dp    = dp_reg;
    assign err   = err_reg;
    assign frame = boundary;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan
//
// Self-checking bench for bcd_seg_scan with SCAN_DIV=4, BLINK_DIV=64.
// The reference model works from elapsed clock count: digit slot, frame
// boundary and blink phase are plain divisions of the cycle number, and
// each digit is extracted from the displayed value arithmetically.
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

    localparam int SD = 4;
    localparam int BD = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd;
    logic        valid;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;
    logic        err;

    bcd_seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd      (bcd),
        .valid    (valid),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .frame    (frame),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: clocks since reset release, displayed / pending values.
    int n;
    int m_disp;
    int m_pend;
    bit m_flag;

    logic [6:0] seg_tab [16];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, n);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_disp = 0;
        m_pend = 0;
        m_flag = 0;
    endtask

    // One clock: predict the registered outputs from the pre-edge state,
    // advance the model, then compare shortly after the edge.
    task automatic step();
        int         idx;
        int         nib;
        bit         bnd;
        bit         ph;
        bit         blanked;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_err;
        logic       e_frame;
        @(posedge clk);
        idx     = (n / SD) % 4;
        bnd     = (n % (4 * SD)) == (4 * SD - 1);
        ph      = ((n / BD) % 2) == 1;
        nib     = (m_disp >> (4 * idx)) & 15;
        blanked = blank_lz && (idx != 0) && ((m_disp >> (4 * idx)) == 0);
        e_an      = 4'b1111;
        e_an[idx] = 1'b0;
        e_seg     = blanked ? 7'b1111111 : seg_tab[nib];
        e_dp      = blanked ? 1'b1 : !dp_mask[idx];
        if (blink_en && ph) begin
            e_an = 4'b1111;
            e_dp = 1'b1;
        end
        e_err = 1'b0;
        for (int k = 0; k < 4; k++)
            if (((m_disp >> (4 * k)) & 15) > 9) e_err = 1'b1;
        if (valid && bnd) begin
            m_disp = int'(bcd);
            m_flag = 0;
        end else begin
            if (bnd && m_flag) begin
                m_disp = m_pend;
                m_flag = 0;
            end
            if (valid) begin
                m_pend = int'(bcd);
                m_flag = 1;
            end
        end
        n++;
        e_frame = (n % (4 * SD)) == (4 * SD - 1);
        #1;
        chk("an",    16'(an),    16'(e_an));
        chk("seg",   16'(seg),   16'(e_seg));
        chk("dp",    16'(dp),    16'(e_dp));
        chk("err",   16'(err),   16'(e_err));
        chk("frame", 16'(frame), 16'(e_frame));
        @(negedge clk);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic load(input logic [15:0] v);
        bcd   = v;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    // Step until the next edge sees slot position p within the frame.
    task automatic align(input int p);
        for (int i = 0; i < 4 * SD; i++)
            if ((n % (4 * SD)) != p) step();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_an",    16'(an),    16'h000f);
        chk("rst_seg",   16'(seg),   16'h007f);
        chk("rst_dp",    16'(dp),    16'h0001);
        chk("rst_err",   16'(err),   16'h0000);
        chk("rst_frame", 16'(frame), 16'h0000);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

        reset    = 1'b1;
        bcd      = 16'h0000;
        valid    = 1'b0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        dp_mask  = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;

        // First frame after reset: "0000", anodes walking from the ones digit.
        run(16);

        // Mid-frame load waits for the next boundary.
        align(6);
        load(16'h1234);
        run(40);

        // Two loads in one frame: the last wins; leading zeros blanked.
        blank_lz = 1'b1;
        align(1);
        load(16'h0005);
        run(3);
        load(16'h0042);
        run(40);
        load(16'h0000);
        run(36);

        // Load on the exact boundary cycle.
        align(4 * SD - 1);
        load(16'h9999);
        run(20);

        // Non-decimal nibble raises err; a clean value clears it.
        load(16'h12A4);
        run(20);
        load(16'h1204);
        run(36);

        // Blink with a single decimal point on digit 2.
        blank_lz = 1'b0;
        blink_en = 1'b1;
        dp_mask  = 4'b0100;
        run(256);
        blink_en = 1'b0;
        dp_mask  = 4'b0000;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            blank_lz = 1'($urandom_range(0, 1));
            dp_mask  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
            bcd   = rand_bcd();
            valid = ($urandom_range(0, 7) == 0);
            step();
            valid = 1'b0;
        end

        // Asynchronous reset in the middle of a frame with err set.
        blink_en = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        load(16'h12A4);
        run(20);
        align(7);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
